// File: rtl/silly_pkg.sv
// Shared keypad definitions for key_conditioner and input_driver.
// Bit map: 16 = octave up, 15 = octave down, 14 = mode, 13 = goof, 12:0 = note keys.
package silly_pkg;

    localparam int N_KEYS = 17;

    typedef logic [N_KEYS-1:0] keypad_t;

    localparam int KEY_OCT_UP   = 16;
    localparam int KEY_OCT_DN   = 15;
    localparam int KEY_MODE     = 14;
    localparam int KEY_GOOF     = 13;
    localparam int KEY_NOTE_MSB = 12;

    // Larger of two integers, used when sizing shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One keypad bit: synchronizer chain, debounce counter, clean level and
// one-cycle press/release pulses. All state advances only on the shared tick.
module key_debounce_cell #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_SAMPLES = 50
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    input  logic tick,
    input  logic repeat_req,
    output logic accept,
    output logic clean,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [CW-1:0]          cnt;

    // Shift the raw level through the metastability chain
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // High on the tick where this bit's new level has been seen often enough
    assign accept = tick && (sync_q != clean) && (cnt == LAST);

    // Count consecutive differing samples, flip the clean level and pulse on acceptance
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt           <= '0;
            clean         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (tick) begin
                if (sync_q == clean) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt           <= '0;
                    clean         <= ~clean;
                    press_pulse   <= ~clean;
                    release_pulse <= clean;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (repeat_req) begin
                    press_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Keypad front end: synchronizes and debounces the 17-bit keypad, emits
// per-key press/release pulses and a single change strobe.
// Optional autorepeat of the octave keys is built when
// KEY_CONDITIONER_AUTOREPEAT_EN is defined.
module key_conditioner
    import silly_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int SAMPLE_DIV          = 1000,
    parameter int STABLE_SAMPLES      = 50,
    parameter int REPEAT_DELAY_TICKS  = 5000,
    parameter int REPEAT_PERIOD_TICKS = 2000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_KEYS-1:0] keypad_raw,
    output logic [N_KEYS-1:0] keypad_clean,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              change_strobe
);

    localparam int PW = $clog2(SAMPLE_DIV);

    logic [PW-1:0]     pcnt;
    logic              tick;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] rep_fire;

    // Free-running sample prescaler, wraps after SAMPLE_DIV clocks
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pcnt <= '0;
        end else if (pcnt == PW'(SAMPLE_DIV - 1)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == PW'(SAMPLE_DIV - 1));

    for (genvar k = 0; k < N_KEYS; k++) begin : g_cell
        key_debounce_cell #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_cell (
            .clk          (clk),
            .nrst         (nrst),
            .raw          (keypad_raw[k]),
            .tick         (tick),
            .repeat_req   (rep_fire[k]),
            .accept       (accept[k]),
            .clean        (keypad_clean[k]),
            .press_pulse  (key_press[k]),
            .release_pulse(key_release[k])
        );
    end

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS) + 1);

    logic [1:0] rep_hit;

    for (genvar r = 0; r < 2; r++) begin : g_rep
        localparam int K = (r == 0) ? KEY_OCT_DN : KEY_OCT_UP;

        logic [RW-1:0] rep_cnt;
        logic [RW-1:0] rep_last;
        logic          rep_armed;

        // First repeat waits the hold delay, later ones use the shorter period;
        // a tick that is also releasing the key never repeats
        assign rep_last   = rep_armed ? RW'(REPEAT_PERIOD_TICKS - 1) : RW'(REPEAT_DELAY_TICKS - 1);
        assign rep_hit[r] = tick && keypad_clean[K] && !accept[K] && (rep_cnt == rep_last);

        // Count ticks while the octave key is held, restarting after each repeat
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (!keypad_clean[K]) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (tick) begin
                if (rep_hit[r]) begin
                    rep_cnt   <= '0;
                    rep_armed <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

    // Route the two repeat requests onto their keypad bits
    always_comb begin
        rep_fire             = '0;
        rep_fire[KEY_OCT_DN] = rep_hit[0];
        rep_fire[KEY_OCT_UP] = rep_hit[1];
    end
`else
    assign rep_fire = '0;
`endif

    // One strobe for any edge or repeat accepted on this tick
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            change_strobe <= 1'b0;
        end else begin
            change_strobe <= |(accept | rep_fire);
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with SAMPLE_DIV=4, STABLE_SAMPLES=3, SYNC_STAGES=2.
// Expected pulse events are queued when the keypad is driven and matched
// against the DUT whenever any press/release/strobe output is high.
module tb_key_conditioner;

    import silly_pkg::*;

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic [16:0] keypad_raw;
    logic [16:0] keypad_clean;
    logic [16:0] key_press;
    logic [16:0] key_release;
    logic        change_strobe;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_evt = 0;

    typedef struct {
        logic [16:0] press;
        logic [16:0] rel;
        logic [16:0] clean;
        int          base;
        int          lo;
        int          hi;
        bit          from_prev;
    } exp_t;

    typedef struct {
        logic [16:0] raw;
        logic [16:0] press;
        logic [16:0] rel;
        logic [16:0] clean;
        int          hold;
        int          reps;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    key_conditioner #(
        .SYNC_STAGES        (2),
        .SAMPLE_DIV         (4),
        .STABLE_SAMPLES     (3),
        .REPEAT_DELAY_TICKS (3),
        .REPEAT_PERIOD_TICKS(2)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .keypad_raw   (keypad_raw),
        .keypad_clean (keypad_clean),
        .key_press    (key_press),
        .key_release  (key_release),
        .change_strobe(change_strobe)
    );

    always #5 clk = ~clk;

    // Clock edge counter used to time every pulse
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic [16:0] raw);
        keypad_raw = raw;
    endtask

    task automatic expect_event(input logic [16:0] press, input logic [16:0] rel,
                                input logic [16:0] clean, input int lo, input int hi,
                                input bit from_prev);
        exp_t e;
        e.press     = press;
        e.rel       = rel;
        e.clean     = clean;
        e.base      = cyc;
        e.lo        = lo;
        e.hi        = hi;
        e.from_prev = from_prev;
        sbq.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_clean"},   keypad_clean,  32'h0);
        check_output({tag, "_press"},   key_press,     32'h0);
        check_output({tag, "_release"}, key_release,   32'h0);
        check_output({tag, "_strobe"},  change_strobe, 32'h0);
    endtask

    // Match every output pulse against the next queued expectation, and
    // flag expectations whose time window has run out
    always @(negedge clk) begin : monitor
        exp_t e;
        int   base;
        if (nrst) begin
            if (sbq.size() > 0) begin
                base = sbq[0].from_prev ? last_evt : sbq[0].base;
                if (cyc > base + sbq[0].hi) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL event_timeout: got no pulse expected press=%h release=%h by cycle %0d",
                             sbq[0].press, sbq[0].rel, base + sbq[0].hi);
                    last_evt = cyc;
                    void'(sbq.pop_front());
                end
            end
            if ((|key_press) || (|key_release) || change_strobe) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: got press=%h release=%h strobe=%b expected none (cycle %0d)",
                             key_press, key_release, change_strobe, cyc);
                end else begin
                    e    = sbq.pop_front();
                    base = e.from_prev ? last_evt : e.base;
                    check_output("ev_press",   key_press,     e.press);
                    check_output("ev_release", key_release,   e.rel);
                    check_output("ev_clean",   keypad_clean,  e.clean);
                    check_output("ev_strobe",  change_strobe, 32'h1);
                    check_output("ev_overlap", key_press & key_release, 32'h0);
                    check_range("ev_latency", cyc - base, e.lo, e.hi);
                    last_evt = cyc;
                end
            end
        end
    end

    initial begin
        // Table of keypad patterns following the reset test
        vecs[0] = '{raw: 17'h00000, press: 17'h00000, rel: 17'h1FFFF, clean: 17'h00000, hold: 30, reps: 0};
        vecs[1] = '{raw: 17'h00001, press: 17'h00001, rel: 17'h00000, clean: 17'h00001, hold: 40, reps: 0};
        vecs[2] = '{raw: 17'h00000, press: 17'h00000, rel: 17'h00001, clean: 17'h00000, hold: 30, reps: 0};
        vecs[3] = '{raw: 17'h10008, press: 17'h10008, rel: 17'h00000, clean: 17'h10008, hold: 20, reps: AR};
        vecs[4] = '{raw: 17'h00000, press: 17'h00000, rel: 17'h10008, clean: 17'h00000, hold: 30, reps: 0};
        vecs[5] = '{raw: 17'h04000, press: 17'h04000, rel: 17'h00000, clean: 17'h04000, hold: 30, reps: 0};
        vecs[6] = '{raw: 17'h00002, press: 17'h00002, rel: 17'h04000, clean: 17'h00002, hold: 30, reps: 0};
        vecs[7] = '{raw: 17'h00000, press: 17'h00000, rel: 17'h00002, clean: 17'h00000, hold: 30, reps: 0};

        // Reset with every key held: outputs stay low, then all keys qualify together
        nrst       = 1'b0;
        keypad_raw = 17'h1FFFF;
        wait_cycles(5);
        check_all_zero("reset_hold");
        nrst = 1'b1;
        expect_event(17'h1FFFF, 17'h00000, 17'h1FFFF, 11, 14, 1'b0);
        wait_cycles(30);
        check_output("all_keys_clean", keypad_clean, 32'h1FFFF);

        // Table-driven patterns
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].raw);
            if ((vecs[i].press | vecs[i].rel) != 17'h0)
                expect_event(vecs[i].press, vecs[i].rel, vecs[i].clean, 11, 14, 1'b0);
            for (int r = 0; r < vecs[i].reps; r++)
                expect_event(17'h10000, 17'h00000, vecs[i].clean, 12, 12, 1'b1);
            wait_cycles(vecs[i].hold);
            check_output($sformatf("vec%0d_clean", i), keypad_clean, vecs[i].clean);
        end

        // Short glitch on bit 5 never qualifies
        apply_stimulus(17'h00020);
        wait_cycles(6);
        apply_stimulus(17'h00000);
        wait_cycles(30);
        check_output("glitch_clean", keypad_clean, 32'h0);

        // Reset in the middle of debouncing bit 7 discards the count
        apply_stimulus(17'h00080);
        wait_cycles(9);
        nrst = 1'b0;
        wait_cycles(3);
        check_all_zero("mid_reset");
        nrst = 1'b1;
        expect_event(17'h00080, 17'h00000, 17'h00080, 11, 14, 1'b0);
        wait_cycles(30);
        check_output("post_reset_clean", keypad_clean, 32'h80);
        apply_stimulus(17'h00000);
        expect_event(17'h00000, 17'h00080, 17'h00000, 11, 14, 1'b0);
        wait_cycles(30);

        // Note key 12 held long: exactly one press
        apply_stimulus(17'h01000);
        expect_event(17'h01000, 17'h00000, 17'h01000, 11, 14, 1'b0);
        wait_cycles(60);
        apply_stimulus(17'h00000);
        expect_event(17'h00000, 17'h01000, 17'h00000, 11, 14, 1'b0);
        wait_cycles(30);

        // Octave-up key held: repeats at +12 then every 8 clocks when built with autorepeat
        apply_stimulus(17'h10000);
        expect_event(17'h10000, 17'h00000, 17'h10000, 11, 14, 1'b0);
        for (int r = 0; r < 4 * AR; r++)
            expect_event(17'h10000, 17'h00000, 17'h10000, (r == 0) ? 12 : 8, (r == 0) ? 12 : 8, 1'b1);
        wait_cycles(44);
        apply_stimulus(17'h00000);
        expect_event(17'h00000, 17'h10000, 17'h00000, 11, 14, 1'b0);
        wait_cycles(30);

        check_output("queue_drained", sbq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
